// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode/funct constants, in_op kinds, FSM state type and word packers
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_BEQ   = 6'd4;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_LUI   = 6'd15;
  localparam logic [5:0] OPC_LW    = 6'd35;
  localparam logic [5:0] OPC_SW    = 6'd43;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Instruction kind presented on in_op; 10..15 are illegal
  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_ADDI = 4'd5,
    KIND_LW   = 4'd6,
    KIND_SW   = 4'd7,
    KIND_BEQ  = 4'd8,
    KIND_LUI  = 4'd9
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // {op, rs, rt, rd, shamt=0, funct}
  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  // {op, rs, rt, imm}
  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational field-to-word packing and illegal kind detection
module instr_field_pack
  import mips_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Decode the kind into its opcode/funct and assemble the word; rd is dropped for I-type
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      KIND_ADD:  word_o = pack_r(rs_i, rt_i, rd_i, FN_ADD);
      KIND_SUB:  word_o = pack_r(rs_i, rt_i, rd_i, FN_SUB);
      KIND_AND:  word_o = pack_r(rs_i, rt_i, rd_i, FN_AND);
      KIND_OR:   word_o = pack_r(rs_i, rt_i, rd_i, FN_OR);
      KIND_SLT:  word_o = pack_r(rs_i, rt_i, rd_i, FN_SLT);
      KIND_ADDI: word_o = pack_i(OPC_ADDI, rs_i, rt_i, imm_i);
      KIND_LW:   word_o = pack_i(OPC_LW, rs_i, rt_i, imm_i);
      KIND_SW:   word_o = pack_i(OPC_SW, rs_i, rt_i, imm_i);
      KIND_BEQ:  word_o = pack_i(OPC_BEQ, rs_i, rt_i, imm_i);
      KIND_LUI:  word_o = pack_i(OPC_LUI, 5'd0, rt_i, imm_i);
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - instruction encoder writing packed words to imem; IMEM_ADDR_WRAP_EN selects pointer wrap vs FULL stop
module instr_encoder
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic [8:0]  count,
  output logic        full,
  output logic        err
);

  state_e      state_q;
  logic [7:0]  ptr_q, ptr_d;
  logic [8:0]  count_q, count_d;
  logic        full_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic [31:0] packed_word;
  logic        op_illegal;
  logic        handshake;

  instr_field_pack u_pack (
    .op_i      (in_op),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .word_o    (packed_word),
    .illegal_o (op_illegal)
  );

  // Ready only while idle, out of reset and not being cleared
  assign in_ready  = rst_n & ~clr & (state_q == ST_IDLE);
  assign handshake = in_valid & in_ready;

  // Next pointer and count applied when a write retires
  always_comb begin
    ptr_d = ptr_q + 8'd1;
`ifdef IMEM_ADDR_WRAP_EN
    count_d = (count_q == 9'd256) ? count_q : count_q + 9'd1;
`else
    count_d = count_q + 9'd1;
`endif
  end

  // Control FSM with registered strobe, data, error and bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr) begin
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
          end else if (handshake) begin
            if (op_illegal) begin
              err_q <= 1'b1;
            end else begin
              we_q    <= 1'b1;
              wdata_q <= packed_word;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (clr) begin
            // The strobe already happened this cycle; just discard the advance
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
`ifdef IMEM_ADDR_WRAP_EN
            state_q <= ST_IDLE;
`else
            if (ptr_q == 8'hFF) begin
              full_q  <= 1'b1;
              state_q <= ST_FULL;
            end else begin
              state_q <= ST_IDLE;
            end
`endif
          end
        end
        ST_FULL: begin
          if (clr) begin
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = ptr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder (honours IMEM_ADDR_WRAP_EN)
module tb_instr_encoder;

`ifdef IMEM_ADDR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;
  logic        full, err;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned m_ptr   = 0;
  int unsigned m_count = 0;
  bit          m_full  = 1'b0;
  logic [31:0] cap_wdata;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the instruction-set tables
  function automatic logic [31:0] ref_word(input int unsigned op, input int unsigned rs,
                                           input int unsigned rt, input int unsigned rd,
                                           input int unsigned imm);
    int unsigned functs[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
    int unsigned opcs[5]   = '{8, 35, 43, 4, 15};
    logic [31:0] w;
    if (op < 5) begin
      w = (rs << 21) | (rt << 16) | (rd << 11) | functs[op];
    end else begin
      w = (opcs[op-5] << 26) | (((op == 9) ? 0 : rs) << 21) | (rt << 16) | imm;
    end
    return w;
  endfunction

  task automatic model_clear();
    m_ptr = 0; m_count = 0; m_full = 1'b0;
  endtask

  // Offer one instruction at a negedge and check the resulting cycle(s)
  task automatic send(input int unsigned op, input int unsigned rs, input int unsigned rt,
                      input int unsigned rd, input int unsigned imm);
    logic [31:0] exp_w;
    int unsigned old_ptr;
    exp_w    = ref_word(op, rs, rt, rd, imm);
    in_op    = op[3:0];
    in_rs    = rs[4:0];
    in_rt    = rt[4:0];
    in_rd    = rd[4:0];
    in_imm   = imm[15:0];
    in_valid = 1'b1;
    #1;
    chk("ready_offer", in_ready, m_full ? 0 : 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (m_full) begin
      chk("full_ignore_we", imem_we, 0);
      chk("full_ignore_err", err, 0);
      chk("full_hold", full, 1);
    end else if (op >= 10) begin
      chk("illegal_err", err, 1);
      chk("illegal_we", imem_we, 0);
      chk("illegal_addr", imem_addr, m_ptr);
      @(posedge clk);
      @(negedge clk);
      chk("illegal_err_pulse", err, 0);
      chk("illegal_count", count, m_count);
      chk("illegal_addr_after", imem_addr, m_ptr);
    end else begin
      chk("write_we", imem_we, 1);
      chk("write_addr", imem_addr, m_ptr);
      chk("write_wdata", imem_wdata, exp_w);
      chk("write_ready_low", in_ready, 0);
      cap_wdata = imem_wdata;
      old_ptr = m_ptr;
      m_ptr   = (m_ptr + 1) % 256;
      m_count = WRAP ? ((m_count < 256) ? m_count + 1 : 256) : m_count + 1;
      m_full  = !WRAP && (old_ptr == 255);
      @(posedge clk);
      @(negedge clk);
      chk("write_we_end", imem_we, 0);
      chk("write_count", count, m_count);
      chk("write_full", full, m_full);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_addr", imem_addr, 0);
    rst_n = 1'b1;
    #1;
    chk("release_ready", in_ready, 1);

    send(0, 1, 2, 3, 0);
    chk("add_word", cap_wdata, 32'h00221820);
    chk("add_count", count, 1);

    // Fresh start for the back-to-back pair
    clr = 1'b1; @(posedge clk); @(negedge clk); clr = 1'b0; model_clear();
    send(6, 4, 5, 0, 16'h0010);
    chk("lw_word", cap_wdata, 32'h8C850010);
    send(8, 1, 2, 0, 16'hFFFF);
    chk("beq_word", cap_wdata, 32'h1022FFFF);
    send(9, 9, 7, 0, 16'h1234);
    chk("lui_word", cap_wdata, 32'h3C071234);
    send(12, 3, 3, 3, 16'h0BAD);

    for (int i = 0; i < 40; i++)
      send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 65535));

    // clr together with an offered handshake
    in_op = 4'd1; in_rs = 5'd3; in_valid = 1'b1; clr = 1'b1;
    #1;
    chk("clr_hs_ready", in_ready, 0);
    @(posedge clk); @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; model_clear();
    chk("clr_hs_we", imem_we, 0);
    chk("clr_hs_count", count, 0);
    chk("clr_hs_addr", imem_addr, 0);

    // clr during a WRITE cycle
    send(5, 1, 1, 0, 7);
    send(7, 2, 2, 0, 9);
    in_op = 4'd2; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("clr_wr_we", imem_we, 1);
    chk("clr_wr_addr", imem_addr, 2);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0; model_clear();
    chk("clr_wr_we_end", imem_we, 0);
    chk("clr_wr_count", count, 0);
    chk("clr_wr_addr_end", imem_addr, 0);

    // Reset during a WRITE cycle
    send(3, 4, 4, 4, 0);
    in_op = 4'd0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("rstw_we", imem_we, 1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstw_we_rst", imem_we, 0);
    rst_n = 1'b1; model_clear();
    @(posedge clk); @(negedge clk);
    chk("rstw_we_after", imem_we, 0);
    chk("rstw_count", count, 0);

    // Fill the whole address space
    for (int i = 0; i < 256; i++)
      send($urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 65535));
    chk("fill_count", count, 256);
    chk("fill_full", full, WRAP ? 0 : 1);
    send(1, 5, 6, 7, 0);
    clr = 1'b1; @(posedge clk); @(negedge clk); clr = 1'b0; model_clear();
    chk("fill_clr_full", full, 0);
    chk("fill_clr_count", count, 0);
    send(4, 8, 9, 10, 0);
    chk("fill_after_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have the following ports:
  clk  in  1  system clock, rising edge
  rst_n  in  1  synchronous active-low reset
  clr  in  1  synchronous clear of write pointer, count, full
  in_valid  in  1  instruction fields valid
  in_ready  out  1  block can accept fields this cycle
  in_op  in  4  kind: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 LUI, 10-15 illegal
  in_rs / in_rt / in_rd  in  5 each  register fields
  in_imm  in  16  immediate / branch offset
  imem_we  out  1  instruction-memory write strobe
  imem_addr  out  8  word address of the write
  imem_wdata  out  32  encoded instruction word
  count  out  9  words written since reset/clr (0..256)
  full  out  1  address space exhausted
  err  out  1  one-cycle pulse on illegal in_op
REQ-002 Clock and reset SHALL be a single clock, clk, and a synchronous, active-low reset, rst_n.

Function
REQ-003 The opcodes SHALL be: R-type 0, BEQ 4, ADDI 8, LUI 15, LW 35, SW 43. The funct values SHALL be: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
REQ-004 An R-type word SHALL be {op, rs, rt, rd, shamt=0, funct}. An I-type word SHALL be {op, rs, rt, imm}. LUI SHALL force rs=0. in_rd SHALL be ignored for I-type.
REQ-005 The FSM SHALL have states IDLE, WRITE and FULL. in_ready SHALL be 1 only in IDLE with clr=0.
REQ-006 On a handshake (in_valid & in_ready) at edge N with a legal op, the FSM SHALL go to WRITE. imem_we=1 SHALL hold for exactly the cycle after N, with imem_wdata registered at N and imem_addr equal to the current pointer.
REQ-007 On leaving WRITE, the pointer SHALL increment by 1 (8-bit), count SHALL increment, and the FSM SHALL return to IDLE. Peak throughput SHALL be one word per 2 cycles.
REQ-008 A handshake with an illegal op SHALL be consumed and SHALL produce an err pulse the following cycle. It SHALL cause no imem_we and no pointer or count change, and the FSM SHALL stay in IDLE.
REQ-009 in_valid=1 with in_ready=0 SHALL be ignored. The source SHALL hold its fields until the handshake.
REQ-010 When clr=1, the pointer SHALL go to 0, count to 0, full to 0 and the FSM to IDLE. A WRITE in progress in that cycle SHALL still complete its imem_we, but it SHALL NOT advance the pointer. clr SHALL take priority over a simultaneous handshake, which is not accepted.
REQ-011 Wrap-around behaviour SHALL be as set in REQ-014.

Reset
REQ-012 When rst_n=0 at a clock edge: FSM=IDLE, pointer=0, count=0, full=0, imem_we=0, imem_wdata=0, err=0, in_ready=0. in_ready SHALL read 1 from the first cycle after release.
REQ-013 Reset asserted during WRITE SHALL drop the pending write. No imem_we SHALL follow reset.

Configuration
REQ-014 Macro IMEM_ADDR_WRAP_EN SHALL control pointer wrap:
  defined: after the write to address 255, the pointer SHALL wrap to 0, count SHALL saturate at 256, full SHALL stay 0, and the FSM SHALL never enter FULL.
  undefined: after the write to address 255, the FSM SHALL enter FULL with full=1 and in_ready=0, leaving only on clr or reset.

Structure
REQ-015 A shared package mips_pkg SHALL hold the opcode and funct constants, the in_op kind encoding and the FSM state typedef. The same opcode constants SHALL be used by the main control decoder.
REQ-016 One combinational sub-module, instr_field_pack, SHALL hold the field-to-word packing and illegal-op detection. The FSM, pointer, counters and output registers SHALL live in instr_encoder.

Verification
REQ-017 ADD rs=1 rt=2 rd=3 after reset -> one-cycle imem_we with addr 0x00 and wdata 0x00221820, then count=1.
REQ-018 LW rs=4 rt=5 imm=0x0010, then BEQ rs=1 rt=2 imm=0xFFFF back-to-back -> 0x8C850010 at addr 0, then 0x1022FFFF at addr 1, with in_ready low in each WRITE cycle.
REQ-019 LUI rs=9 rt=7 imm=0x1234 -> wdata 0x3C071234 (rs zeroed).
REQ-020 in_op=12 -> err=1 for one cycle, imem_we=0, and pointer and count unchanged.
REQ-021 256 legal writes -> with IMEM_ADDR_WRAP_EN, the 257th write goes to addr 0 and full stays 0. Without it, full=1, in_ready=0 and in_valid is ignored until clr, after which the next write goes to addr 0.
REQ-022 clr in the same cycle as a handshake and in the same cycle as a WRITE -> handshake not accepted, the pending write strobes, then pointer=0 and count=0. rst_n low during WRITE -> no imem_we.
